// File: rtl/neopixel_pkg.sv
// Shared constants and types for the NeoPixel frame driver.
// Holds 50 MHz default bit timing, pixel widths and the FSM state type.
package neopixel_pkg;

    // Default timing at 50 MHz (1.22 us bit, 50 us latch).
    localparam int T0H_50M          = 20;
    localparam int T1H_50M          = 40;
    localparam int BIT_CYCLES_50M   = 61;
    localparam int RESET_CYCLES_50M = 2500;

    // Supported pixel formats.
    localparam int BPP_GRB  = 24;
    localparam int BPP_GRBW = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        LATCH
    } state_t;

endpackage

// File: rtl/neopixel_bit_timer.sv
// Times one encoded bit: high for T0H/T1H cycles, BIT_CYCLES total.
// Ports: clk, rst_n, bit_start (begin a bit next cycle), bit_val,
//        DO (registered line), bit_last (final cycle of current bit).
module neopixel_bit_timer
    import neopixel_pkg::*;
#(
    parameter int BIT_CYCLES = BIT_CYCLES_50M,
    parameter int T0H        = T0H_50M,
    parameter int T1H        = T1H_50M
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_start,
    input  logic bit_val,
    output logic DO,
    output logic bit_last
);

    localparam int BC_W = $clog2(BIT_CYCLES);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BIT_CYCLES - 1);
    localparam logic [BC_W-1:0] HI0     = BC_W'(T0H);
    localparam logic [BC_W-1:0] HI1     = BC_W'(T1H);

    logic [BC_W-1:0] bc;
    logic            running;

    assign bit_last = running && (bc == BC_LAST);

    // DO is registered from bc, so the line lags the counter by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bc      <= '0;
            running <= 1'b0;
            DO      <= 1'b0;
        end else begin
            DO <= running && (bc < (bit_val ? HI1 : HI0));
            if (bit_start) begin
                running <= 1'b1;
                bc      <= '0;
            end else if (bit_last) begin
                running <= 1'b0;
                bc      <= '0;
            end else if (running) begin
                bc <= bc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/neopixel_frame_driver.sv
// WS2812/SK6812 strip driver: fetches LENGTH pixels from RAM and serialises them.
// Ports: clk, rst_n, start, auto_refresh, pix_rd/pix_addr/pix_data (RAM),
//        busy, done, DO (encoded line).
module neopixel_frame_driver
    import neopixel_pkg::*;
#(
    parameter int LENGTH       = 4,
    parameter int BPP          = BPP_GRB,
    parameter int BIT_CYCLES   = BIT_CYCLES_50M,
    parameter int T0H          = T0H_50M,
    parameter int T1H          = T1H_50M,
    parameter int RESET_CYCLES = RESET_CYCLES_50M,
    localparam int ADDR_W      = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              auto_refresh,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [BPP-1:0]    pix_data,
    output logic              busy,
    output logic              done,
    output logic              DO
);

    localparam int BIT_W = $clog2(BPP);
    localparam int LAT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(LENGTH - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(BPP - 1);
    localparam logic [LAT_W-1:0]  LAST_LAT = LAT_W'(RESET_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [BPP-1:0]    shreg;
    logic [BPP-1:0]    next_buf;
    logic [ADDR_W-1:0] pix_idx;
    logic [BIT_W-1:0]  bit_idx;
    logic [LAT_W-1:0]  lat_cnt;
    logic              pf_slot;
    logic              pf_cap;
    logic              pf_rd;
    logic              bit_start;
    logic              bit_last;
    logic              last_bit;

    neopixel_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES),
        .T0H        (T0H),
        .T1H        (T1H)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_start (bit_start),
        .bit_val   (shreg[BPP-1]),
        .DO        (DO),
        .bit_last  (bit_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bit_start = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        last_bit  = (bit_idx == LAST_BIT);
        // pf_slot marks bc=0 of bit 0; the final pixel has nothing to prefetch.
        pf_rd     = pf_slot && (pix_idx != LAST_PIX);
        pix_rd    = pf_rd;
        pix_addr  = pf_rd ? pix_idx + 1'b1 : '0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                pix_rd    = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                bit_start = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                if (bit_last) begin
                    if (last_bit && pix_idx == LAST_PIX)
                        state_nxt = LATCH;
                    else
                        bit_start = 1'b1;
                end
            end
            LATCH: begin
                if (lat_cnt == LAST_LAT) begin
                    done      = 1'b1;
                    state_nxt = auto_refresh ? FETCH : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg    <= '0;
            next_buf <= '0;
            pix_idx  <= '0;
            bit_idx  <= '0;
            lat_cnt  <= '0;
            pf_slot  <= 1'b0;
            pf_cap   <= 1'b0;
        end else begin
            pf_cap  <= pf_rd;
            pf_slot <= 1'b0;
            if (pf_cap) next_buf <= pix_data;
            if (state == LOAD) begin
                shreg   <= pix_data;
                pix_idx <= '0;
                bit_idx <= '0;
                pf_slot <= 1'b1;
            end else if (state == SEND && bit_start) begin
                if (last_bit) begin
                    // Pixel boundary: next word goes out with no gap.
                    shreg   <= next_buf;
                    pix_idx <= pix_idx + 1'b1;
                    bit_idx <= '0;
                    pf_slot <= 1'b1;
                end else begin
                    shreg   <= {shreg[BPP-2:0], 1'b0};
                    bit_idx <= bit_idx + 1'b1;
                end
            end
            if (state == LATCH && lat_cnt != LAST_LAT)
                lat_cnt <= lat_cnt + 1'b1;
            else
                lat_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_neopixel_frame_driver.sv
// Bench for neopixel_frame_driver: two instances (2x24-bit, 1x32-bit).
// Directed timing checks plus a DO decoder scoreboard over random frames.
module tb_neopixel_frame_driver;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start_b;
    logic        auto_refresh;

    logic        pix_rd_a;
    logic [0:0]  pix_addr_a;
    logic [23:0] rdata_a;
    logic        busy_a;
    logic        done_a;
    logic        DO_a;

    logic        pix_rd_b;
    logic [0:0]  pix_addr_b;
    logic [31:0] rdata_b;
    logic        busy_b;
    logic        done_b;
    logic        DO_b;

    logic [23:0] ram_a [2];
    logic [31:0] ram_b;
    logic [23:0] sb_q [$];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    neopixel_frame_driver #(
        .LENGTH(2), .BPP(24), .BIT_CYCLES(6),
        .T0H(2), .T1H(4), .RESET_CYCLES(10)
    ) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .auto_refresh (auto_refresh),
        .pix_rd       (pix_rd_a),
        .pix_addr     (pix_addr_a),
        .pix_data     (rdata_a),
        .busy         (busy_a),
        .done         (done_a),
        .DO           (DO_a)
    );

    neopixel_frame_driver #(
        .LENGTH(1), .BPP(32), .BIT_CYCLES(6),
        .T0H(2), .T1H(4), .RESET_CYCLES(10)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start_b),
        .auto_refresh (1'b0),
        .pix_rd       (pix_rd_b),
        .pix_addr     (pix_addr_b),
        .pix_data     (rdata_b),
        .busy         (busy_b),
        .done         (done_b),
        .DO           (DO_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pix_rd_a) rdata_a <= ram_a[pix_addr_a];
        if (pix_rd_b) rdata_b <= ram_b;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected DO at cycle k after a start at cycle 0 (line lags bc by 1).
    function automatic logic exp_do(input logic [31:0] w0,
                                    input logic [31:0] w1,
                                    input int bpp,
                                    input int npix,
                                    input int k);
        int idx, b, p;
        logic [31:0] w;
        if (k < 4 || k >= 4 + npix * bpp * 6) return 1'b0;
        idx = k - 4;
        b   = idx / 6;
        p   = idx % 6;
        w   = (b / bpp == 0) ? w0 : w1;
        return p < (w[bpp - 1 - (b % bpp)] ? 4 : 2);
    endfunction

    // DO decoder for instance A: checks high time and period, rebuilds words.
    int          hi = 0;
    int          since_rise = 0;
    int          nbits = 0;
    bit          in_bit = 0;
    logic        prev_do = 1'b0;
    logic [23:0] word = '0;
    logic        exp_bit;

    always @(negedge clk) begin
        if (busy_a !== 1'b1) begin
            in_bit = 0;
            nbits  = 0;
        end else begin
            if (DO_a === 1'b1 && prev_do === 1'b0) begin
                if (in_bit) chk("bit_period", since_rise, 6);
                in_bit     = 1;
                since_rise = 0;
                hi         = 0;
            end
            if (in_bit) begin
                since_rise++;
                if (DO_a === 1'b1) hi++;
                else if (prev_do === 1'b1) begin
                    chk("sb_nonempty", sb_q.size() != 0, 1);
                    if (sb_q.size() != 0) begin
                        exp_bit = sb_q[0][23 - nbits];
                        chk("bit_high", hi, exp_bit ? 4 : 2);
                        word = {word[22:0], hi > 2};
                        nbits++;
                        if (nbits == 24) begin
                            chk("word", word, sb_q[0]);
                            void'(sb_q.pop_front());
                            nbits = 0;
                        end
                    end
                end
                if (since_rise > 6) in_bit = 0;
            end
        end
        prev_do = DO_a;
    end

    // One full frame on instance A, start at relative cycle 0.
    task automatic frame_a(input logic [23:0] w0,
                           input logic [23:0] w1,
                           input bit noise);
        int rd_cnt, done_cnt, done_cyc;
        ram_a[0] = w0;
        ram_a[1] = w1;
        sb_q.push_back(w0);
        sb_q.push_back(w1);
        start = 1'b1;
        step();
        start    = 1'b0;
        rd_cnt   = 0;
        done_cnt = 0;
        done_cyc = -1;
        for (int k = 1; k <= 301; k++) begin
            if (k > 1) step();
            if (noise) start = (k == 50 || k == 200);
            if (k == 1) chk("busy_fetch", busy_a, 1);
            if (pix_rd_a) begin
                rd_cnt++;
                chk("rd_cycle", k, (rd_cnt == 1) ? 1 : 3);
                chk("rd_addr", pix_addr_a, (rd_cnt == 1) ? 0 : 1);
            end
            if (done_a) begin
                done_cnt++;
                done_cyc = k;
            end
            if (k == 300) chk("busy_last", busy_a, 1);
            chk("do_wave", DO_a, exp_do(w0, w1, 24, 2, k));
        end
        start = 1'b0;
        chk("rd_count", rd_cnt, 2);
        chk("done_count", done_cnt, 1);
        chk("done_cycle", done_cyc, 300);
        chk("busy_after", busy_a, 0);
    endtask

    initial begin
        int rd_cnt, done_cnt, done_cyc, low_busy;
        int dq [$];
        logic [23:0] r0, r1;

        rst_n        = 1'b0;
        start        = 1'b0;
        start_b      = 1'b0;
        auto_refresh = 1'b0;
        ram_a[0]     = '0;
        ram_a[1]     = '0;
        ram_b        = '0;
        repeat (3) step();

        chk("rst_do", DO_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_rd", pix_rd_a, 0);
        chk("rst_addr", pix_addr_a, 0);
        chk("rst_b_busy", busy_b, 0);
        rst_n = 1'b1;
        repeat (2) step();

        // Basic frame, then a frame with stray start pulses.
        frame_a(24'h00FF00, 24'h800001, 0);
        repeat (3) step();
        frame_a(24'h00FF00, 24'h800001, 1);
        repeat (3) step();

        // Continuous refresh for three frames.
        ram_a[0] = 24'hC3A501;
        ram_a[1] = 24'h5A0F80;
        repeat (3) begin
            sb_q.push_back(ram_a[0]);
            sb_q.push_back(ram_a[1]);
        end
        auto_refresh = 1'b1;
        start        = 1'b1;
        step();
        start    = 1'b0;
        low_busy = 0;
        for (int k = 1; k <= 901; k++) begin
            if (k > 1) step();
            if (k == 601) auto_refresh = 1'b0;
            if (done_a) dq.push_back(k);
            if (k <= 900 && !busy_a) low_busy++;
            if (k == 301 || k == 601) begin
                chk("ar_rd", pix_rd_a, 1);
                chk("ar_addr", pix_addr_a, 0);
            end
            chk("ar_do_wave", DO_a,
                exp_do(ram_a[0], ram_a[1], 24, 2, ((k - 1) % 300) + 1));
        end
        chk("ar_low_busy", low_busy, 0);
        chk("ar_done_n", dq.size(), 3);
        for (int i = 0; i < dq.size(); i++)
            chk("ar_done_cyc", dq[i], 300 * (i + 1));
        chk("ar_busy_end", busy_a, 0);
        repeat (3) step();

        // Reset in the middle of SEND, then replay.
        ram_a[0] = 24'h00FF00;
        ram_a[1] = 24'h800001;
        sb_q.push_back(ram_a[0]);
        sb_q.push_back(ram_a[1]);
        start = 1'b1;
        step();
        start    = 1'b0;
        done_cnt = 0;
        for (int k = 1; k <= 109; k++) begin
            if (k > 1) step();
            if (k == 100) rst_n = 1'b0;
            if (k == 101) begin
                chk("abort_do", DO_a, 0);
                chk("abort_busy", busy_a, 0);
                chk("abort_rd", pix_rd_a, 0);
                rst_n = 1'b1;
                sb_q.delete();
            end
            if (done_a) done_cnt++;
        end
        chk("abort_done", done_cnt, 0);
        step();
        frame_a(24'h00FF00, 24'h800001, 0);
        repeat (3) step();

        // Single 32-bit pixel on instance B.
        ram_b   = 32'hA5000000;
        start_b = 1'b1;
        step();
        start_b  = 1'b0;
        rd_cnt   = 0;
        done_cyc = -1;
        for (int k = 1; k <= 205; k++) begin
            if (k > 1) step();
            if (pix_rd_b) begin
                rd_cnt++;
                chk("b_rd_cycle", k, 1);
                chk("b_rd_addr", pix_addr_b, 0);
            end
            if (done_b) done_cyc = k;
            chk("b_do_wave", DO_b, exp_do(ram_b, '0, 32, 1, k));
        end
        chk("b_rd_count", rd_cnt, 1);
        chk("b_done_cycle", done_cyc, 204);
        chk("b_busy_after", busy_b, 0);
        repeat (2) step();

        // Random frames checked by the decoder scoreboard.
        for (int f = 0; f < 100; f++) begin
            r0       = 24'($urandom);
            r1       = 24'($urandom);
            ram_a[0] = r0;
            ram_a[1] = r1;
            sb_q.push_back(r0);
            sb_q.push_back(r1);
            start = 1'b1;
            step();
            start    = 1'b0;
            done_cyc = -1;
            for (int k = 1; k <= 400; k++) begin
                if (done_a) begin
                    done_cyc = k;
                    break;
                end
                step();
            end
            chk("rand_done_cycle", done_cyc, 300);
            repeat (2) step();
        end
        repeat (4) step();
        chk("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
